// File: rtl/clk_cfg_pkg.sv
// rtl/clk_cfg_pkg.sv - shared types, widths and constants for the clock-config sequencer
package clk_cfg_pkg;

    localparam int DEV_W         = 2;
    localparam int NUM_WORDS_MAX = 16;
    localparam int IDX_W         = $clog2(NUM_WORDS_MAX + 1);
    localparam int CNT_W         = 16;

    localparam logic [31:0] CFG_END_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_GO_HI   = 3'd2,
        ST_GO_LO   = 3'd3,
        ST_NEXTDEV = 3'd4,
        ST_SYNC    = 3'd5,
        ST_LOCK    = 3'd6,
        ST_PASS    = 3'd7
    } state_t;

    function automatic logic is_end_word(input logic [31:0] word);
        return word == CFG_END_WORD;
    endfunction

endpackage

// File: rtl/clk_cfg_rom.sv
// rtl/clk_cfg_rom.sv - fixed jitter-cleaner register table indexed by {dev, idx}
module clk_cfg_rom
    import clk_cfg_pkg::*;
(
    input  logic [DEV_W-1:0] dev,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      word
);

    // Table lookup; any slot not listed reads back as the end-of-device marker
    always_comb begin
        word = CFG_END_WORD;
        casez ({dev, idx})
            {2'd0, 5'd0}:     word = 32'h0A00_0011;
            {2'd0, 5'd1}:     word = 32'h0A00_0122;
            {2'd0, 5'd2}:     word = 32'h0A00_0233;
            {2'd0, 5'd3}:     word = 32'h0A00_0344;
            {2'd1, 5'd0}:     word = 32'h1B00_0155;
            {2'd1, 5'd1}:     word = 32'h1B00_0266;
            {2'd1, 5'd2}:     word = 32'h1B00_0377;
            // device 2 fills every slot, so its run ends on the slot limit
            {2'd2, 5'b0????}: word = {16'h2C00, 11'd0, idx};
            default:          word = CFG_END_WORD;
        endcase
    end

endmodule

// File: rtl/clk_cfg_sequencer.sv
// rtl/clk_cfg_sequencer.sv - jitter-cleaner SPI table loader with host pass-through; option CLK_CFG_AUTOSTART_EN
module clk_cfg_sequencer
    import clk_cfg_pkg::*;
#(
    parameter int NUM_DEV     = 3,
    parameter int NUM_WORDS   = 16,
    parameter int SYNC_CYCLES = 10,
    parameter int LOCK_CYCLES = 1000,
    parameter int TIMEOUT     = 4095
) (
    input  logic        CLK_1MHZ,
    input  logic        RST,
    input  logic        CFG_START,
    input  logic        WB_SPI_GO,
    input  logic [31:0] WB_SPI_DATA,
    input  logic [1:0]  WB_SPI_SEL,
    output logic        WB_SPI_DONE,
    output logic [31:0] WB_SPI_RDBK,
    output logic [31:0] SPI_O,
    output logic [1:0]  SPI_SEL_O,
    output logic        SPI_GO,
    input  logic        SPI_DONE,
    input  logic [31:0] SPI_I,
    output logic        SYNC,
    output logic        CFG_BUSY,
    output logic        CFG_DONE,
    output logic        CFG_ERR
);

    state_t           state;
    state_t           state_nxt;
    logic             go_s1;
    logic             go_s2;
    logic             start_s1;
    logic             start_s2;
    logic             start_s3;
    logic             start_edge;
    logic             auto_edge;
    logic             start_pend;
    logic             start_req;
    logic [DEV_W-1:0] dev;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rom_word;
    logic [31:0]      word_q;
    logic [1:0]       sel_q;
    logic [31:0]      rdbk_q;
    logic             done_q;
    logic             busy_q;
    logic             cfg_done_q;
    logic             err_q;
    logic             slot_empty;
    logic             last_dev;
    logic             abort;
    logic             counting;

    clk_cfg_rom u_rom (
        .dev  (dev),
        .idx  (idx),
        .word (rom_word)
    );

`ifdef CLK_CFG_AUTOSTART_EN
    logic [1:0] auto_cnt;

    // Counts the first cycles out of reset; the internal start fires once on the 2nd
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            auto_cnt <= 2'd0;
        end else if (auto_cnt != 2'd3) begin
            auto_cnt <= auto_cnt + 2'd1;
        end
    end

    assign auto_edge = (auto_cnt == 2'd1);
`else
    assign auto_edge = 1'b0;
`endif

    assign start_edge = (start_s2 & ~start_s3) | auto_edge;
    assign start_req  = start_edge | start_pend;
    assign slot_empty = (idx == IDX_W'(NUM_WORDS)) || is_end_word(rom_word);
    assign last_dev   = (dev == DEV_W'(NUM_DEV - 1));
    assign counting   = state inside {ST_GO_HI, ST_GO_LO, ST_SYNC, ST_LOCK};
    // A handshake edge that has not arrived by the last allowed cycle aborts the run
    assign abort      = (cnt == CNT_W'(TIMEOUT - 1)) &&
                        (((state == ST_GO_HI) && !SPI_DONE) ||
                         ((state == ST_GO_LO) && SPI_DONE));

    // Bring host-domain levels into CLK_1MHZ; an extra stage on start gives the edge
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            go_s1    <= 1'b0;
            go_s2    <= 1'b0;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
        end else begin
            go_s1    <= WB_SPI_GO;
            go_s2    <= go_s1;
            start_s1 <= CFG_START;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
        end
    end

    // State register
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_LOAD;
                end else if (go_s2) begin
                    state_nxt = ST_PASS;
                end
            end
            ST_LOAD:    state_nxt = slot_empty ? ST_NEXTDEV : ST_GO_HI;
            ST_GO_HI: begin
                if (SPI_DONE) begin
                    state_nxt = ST_GO_LO;
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GO_LO: begin
                if (!SPI_DONE) begin
                    state_nxt = ST_LOAD;
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_NEXTDEV: state_nxt = last_dev ? ST_SYNC : ST_LOAD;
            ST_SYNC: begin
                if (cnt == CNT_W'(SYNC_CYCLES - 1)) begin
                    state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (!go_s2 && !SPI_DONE) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Per-state cycle counter, cleared on every state change
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (counting) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Table pointer: restart at dev0/idx0, step idx per word, step dev per marker
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            dev <= '0;
            idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        dev <= '0;
                        idx <= '0;
                    end
                end
                ST_GO_LO: begin
                    if (!SPI_DONE) begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_NEXTDEV: begin
                    if (!last_dev) begin
                        dev <= dev + 1'b1;
                        idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Hold a start edge that arrives during a host transfer until IDLE can serve it
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            start_pend <= 1'b0;
        end else if (state == ST_IDLE) begin
            start_pend <= 1'b0;
        end else if ((state == ST_PASS) && start_edge) begin
            start_pend <= 1'b1;
        end
    end

    // SPI word and select are only loaded while SPI_GO is low, so they stay stable across a transfer
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            word_q <= '0;
            sel_q  <= '0;
        end else if ((state == ST_LOAD) && !slot_empty) begin
            word_q <= rom_word;
            sel_q  <= dev;
        end else if ((state == ST_IDLE) && !start_req && go_s2) begin
            word_q <= WB_SPI_DATA;
            sel_q  <= WB_SPI_SEL;
        end
    end

    // Capture the SPI readback on every rising SPI_DONE, whoever owns the bus
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            done_q <= 1'b0;
            rdbk_q <= '0;
        end else begin
            done_q <= SPI_DONE;
            if (SPI_DONE && !done_q) begin
                rdbk_q <= SPI_I;
            end
        end
    end

    // Run status: set on start, resolved by lock completion or a handshake timeout
    always_ff @(posedge CLK_1MHZ or negedge RST) begin
        if (!RST) begin
            busy_q     <= 1'b0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else if ((state == ST_IDLE) && start_req) begin
            busy_q     <= 1'b1;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else if ((state == ST_LOCK) && (state_nxt == ST_IDLE)) begin
            busy_q     <= 1'b0;
            cfg_done_q <= 1'b1;
        end else if (abort) begin
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
        end
    end

    // State-decoded outputs
    always_comb begin
        SPI_GO      = 1'b0;
        SYNC        = 1'b0;
        WB_SPI_DONE = 1'b0;
        case (state)
            ST_GO_HI: SPI_GO = 1'b1;
            ST_SYNC:  SYNC   = 1'b1;
            ST_PASS: begin
                SPI_GO      = go_s2;
                WB_SPI_DONE = SPI_DONE;
            end
            default: ;
        endcase
    end

    assign SPI_O       = word_q;
    assign SPI_SEL_O   = sel_q;
    assign WB_SPI_RDBK = rdbk_q;
    assign CFG_BUSY    = busy_q;
    assign CFG_DONE    = cfg_done_q;
    assign CFG_ERR     = err_q;

endmodule

// File: tb/tb_clk_cfg_sequencer.sv
// tb/tb_clk_cfg_sequencer.sv - self-checking bench for clk_cfg_sequencer
module tb_clk_cfg_sequencer;

    logic        CLK_1MHZ    = 1'b0;
    logic        RST         = 1'b0;
    logic        CFG_START   = 1'b0;
    logic        WB_SPI_GO   = 1'b0;
    logic [31:0] WB_SPI_DATA = '0;
    logic [1:0]  WB_SPI_SEL  = '0;
    logic        WB_SPI_DONE;
    logic [31:0] WB_SPI_RDBK;
    logic [31:0] SPI_O;
    logic [1:0]  SPI_SEL_O;
    logic        SPI_GO;
    logic        SPI_DONE    = 1'b0;
    logic [31:0] SPI_I       = '0;
    logic        SYNC;
    logic        CFG_BUSY;
    logic        CFG_DONE;
    logic        CFG_ERR;

    clk_cfg_sequencer dut (
        .CLK_1MHZ    (CLK_1MHZ),
        .RST         (RST),
        .CFG_START   (CFG_START),
        .WB_SPI_GO   (WB_SPI_GO),
        .WB_SPI_DATA (WB_SPI_DATA),
        .WB_SPI_SEL  (WB_SPI_SEL),
        .WB_SPI_DONE (WB_SPI_DONE),
        .WB_SPI_RDBK (WB_SPI_RDBK),
        .SPI_O       (SPI_O),
        .SPI_SEL_O   (SPI_SEL_O),
        .SPI_GO      (SPI_GO),
        .SPI_DONE    (SPI_DONE),
        .SPI_I       (SPI_I),
        .SYNC        (SYNC),
        .CFG_BUSY    (CFG_BUSY),
        .CFG_DONE    (CFG_DONE),
        .CFG_ERR     (CFG_ERR)
    );

    always #5 CLK_1MHZ = ~CLK_1MHZ;

`ifdef CLK_CFG_AUTOSTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference table: words before each device's marker (device 2 fills all 16 slots)
    logic [31:0] tbl0 [4] = '{32'h0A00_0011, 32'h0A00_0122, 32'h0A00_0233, 32'h0A00_0344};
    logic [31:0] tbl1 [3] = '{32'h1B00_0155, 32'h1B00_0266, 32'h1B00_0377};

    logic [33:0] exp_q [$];
    bit          run_active = 1'b0;
    int          go_cnt [3];
    int          go_total;
    logic [31:0] first_word;
    logic [31:0] last_word;

    bit          hang_en   = 1'b0;
    logic [31:0] hang_word = 32'h0A00_0233;
    int          spi_cnt   = 0;

    logic        go_prev   = 1'b0;
    logic        done_prev = 1'b0;
    logic [1:0]  sel_at_go = '0;
    logic [31:0] rdbk_exp  = '0;
    logic [31:0] rdbk_next = '0;
    bit          rdbk_arm  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // SPI_MODULE stand-in: DONE 5 cycles after GO, held until GO drops; readback = halves swapped
    initial begin
        forever begin
            @(posedge CLK_1MHZ);
            #1;
            if (SPI_GO) begin
                if (!SPI_DONE) begin
                    spi_cnt++;
                    if (spi_cnt >= 5 && !(hang_en && SPI_O == hang_word)) begin
                        SPI_I    = {SPI_O[15:0], SPI_O[31:16]};
                        SPI_DONE = 1'b1;
                    end
                end
            end else begin
                spi_cnt  = 0;
                SPI_DONE = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model: word order, select stability, readback, status
    always @(negedge CLK_1MHZ) begin
        if (!RST) begin
            go_prev   = 1'b0;
            done_prev = 1'b0;
            rdbk_exp  = '0;
            rdbk_arm  = 1'b0;
        end else begin
            if (rdbk_arm) begin
                rdbk_exp = rdbk_next;
                rdbk_arm = 1'b0;
            end
            if (SPI_DONE && !done_prev) begin
                rdbk_next = SPI_I;
                rdbk_arm  = 1'b1;
            end
            chk("rdbk_track", WB_SPI_RDBK, rdbk_exp);
            if (SPI_GO && !go_prev) begin
                sel_at_go = SPI_SEL_O;
                if (run_active) begin
                    chk("go_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        logic [33:0] e;
                        e = exp_q.pop_front();
                        chk("go_word", SPI_O, e[31:0]);
                        chk("go_sel", 32'(SPI_SEL_O), 32'(e[33:32]));
                    end
                    if (go_total == 0) first_word = SPI_O;
                    last_word = SPI_O;
                    go_total++;
                    go_cnt[SPI_SEL_O]++;
                end
            end
            if (SPI_GO) chk("sel_stable", 32'(SPI_SEL_O), 32'(sel_at_go));
            if (run_active) begin
                chk("wb_done_quiet", 32'(WB_SPI_DONE), 32'd0);
                if (SYNC) chk("sync_after_table", exp_q.size(), 0);
            end
            go_prev   = SPI_GO;
            done_prev = SPI_DONE;
        end
    end

    task automatic load_expect();
        exp_q.delete();
        foreach (tbl0[i]) exp_q.push_back({2'd0, tbl0[i]});
        foreach (tbl1[i]) exp_q.push_back({2'd1, tbl1[i]});
        for (int i = 0; i < 16; i++) exp_q.push_back({2'd2, 32'h2C00_0000 + 32'(i)});
        go_cnt     = '{0, 0, 0};
        go_total   = 0;
        first_word = '0;
        last_word  = '0;
    endtask

    task automatic pulse_start();
        CFG_START = 1'b1;
        repeat (3) @(negedge CLK_1MHZ);
        CFG_START = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int g = 0;
        while (!CFG_BUSY && g < 40) begin
            @(negedge CLK_1MHZ);
            g++;
        end
        chk(name, 32'(g < 40), 32'd1);
        run_active = 1'b1;
    endtask

    task automatic finish_run();
        int g = 0;
        int n = 0;
        while (!SYNC && g < 3000) begin
            @(negedge CLK_1MHZ);
            g++;
        end
        chk("sync_seen", 32'(g < 3000), 32'd1);
        chk("all_words_issued", exp_q.size(), 0);
        while (SYNC && n < 100) begin
            n++;
            @(negedge CLK_1MHZ);
        end
        chk("sync_len", n, 10);
        n = 0;
        while (!CFG_DONE && n < 5000) begin
            n++;
            @(negedge CLK_1MHZ);
        end
        chk("lock_len", n, 1000);
        chk("run_done", 32'(CFG_DONE), 32'd1);
        chk("run_busy_clr", 32'(CFG_BUSY), 32'd0);
        chk("run_err_clr", 32'(CFG_ERR), 32'd0);
        run_active = 1'b0;
    endtask

    task automatic host_xfer(input logic [31:0] d, input logic [1:0] s, input logic [31:0] rb,
                             input bit start_mid);
        int g = 0;
        WB_SPI_DATA = d;
        WB_SPI_SEL  = s;
        WB_SPI_GO   = 1'b1;
        while (!SPI_GO && g < 50) begin
            @(negedge CLK_1MHZ);
            g++;
        end
        chk("host_go_seen", 32'(g < 50), 32'd1);
        chk("host_spi_o", SPI_O, d);
        chk("host_sel", 32'(SPI_SEL_O), 32'(s));
        if (start_mid) pulse_start();
        g = 0;
        while (!WB_SPI_DONE && g < 50) begin
            chk("host_done_mirror", 32'(WB_SPI_DONE), 32'(SPI_DONE));
            @(negedge CLK_1MHZ);
            g++;
        end
        chk("host_done_seen", 32'(g < 50), 32'd1);
        chk("host_done_hi", 32'(SPI_DONE), 32'd1);
        chk("host_no_run", 32'(CFG_BUSY), 32'd0);
        @(negedge CLK_1MHZ);
        chk("host_rdbk", WB_SPI_RDBK, rb);
        if (start_mid) load_expect();
        WB_SPI_GO = 1'b0;
        if (start_mid) begin
            wait_busy("pend_busy");
            chk("pend_go_low", 32'(SPI_GO), 32'd0);
            chk("pend_wb_done_low", 32'(WB_SPI_DONE), 32'd0);
            finish_run();
            chk("pend_words", go_total, 23);
        end else begin
            repeat (8) begin
                @(negedge CLK_1MHZ);
                chk("host_done_mirror", 32'(WB_SPI_DONE), 32'(SPI_DONE));
            end
            chk("host_go_end", 32'(SPI_GO), 32'd0);
            chk("host_busy_end", 32'(CFG_BUSY), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_go"},   32'(SPI_GO), 32'd0);
        chk({tag, "_spio"}, SPI_O, 32'd0);
        chk({tag, "_sel"},  32'(SPI_SEL_O), 32'd0);
        chk({tag, "_sync"}, 32'(SYNC), 32'd0);
        chk({tag, "_busy"}, 32'(CFG_BUSY), 32'd0);
        chk({tag, "_done"}, 32'(CFG_DONE), 32'd0);
        chk({tag, "_err"},  32'(CFG_ERR), 32'd0);
        chk({tag, "_wbd"},  32'(WB_SPI_DONE), 32'd0);
        chk({tag, "_rdbk"}, WB_SPI_RDBK, 32'd0);
    endtask

    initial begin
        int  g;
        int  n;
        bit  sync_flag;

        // Reset state
        repeat (4) @(negedge CLK_1MHZ);
        chk_all_zero("reset");
        RST = 1'b1;

        // Full table run: order, per-device counts, SYNC width, lock wait
        load_expect();
        if (!AUTO) pulse_start();
        wait_busy("run1_busy");
        finish_run();
        chk("dev0_words", go_cnt[0], 4);
        chk("dev1_words", go_cnt[1], 3);
        chk("dev2_words", go_cnt[2], 16);
        chk("total_words", go_total, 23);
        chk("first_word", first_word, 32'h0A00_0011);
        chk("last_word", last_word, 32'h2C00_000F);

        // Host pass-through while idle
        repeat (3) @(negedge CLK_1MHZ);
        host_xfer(32'h0000_1234, 2'd2, 32'h1234_0000, 1'b0);

        // Start edge during a host transfer is served after PASS ends
        repeat (3) @(negedge CLK_1MHZ);
        host_xfer(32'h0000_BEEF, 2'd1, 32'hBEEF_0000, 1'b1);

        // Handshake timeout on the third word
        repeat (3) @(negedge CLK_1MHZ);
        hang_en = 1'b1;
        load_expect();
        pulse_start();
        wait_busy("hang_busy");
        chk("hang_done_clr", 32'(CFG_DONE), 32'd0);
        g = 0;
        while (!(SPI_GO && SPI_O == hang_word) && g < 200) begin
            @(negedge CLK_1MHZ);
            g++;
        end
        chk("hang_go_seen", 32'(g < 200), 32'd1);
        n = 0;
        sync_flag = 1'b0;
        while (SPI_GO && n < 5000) begin
            if (SYNC) sync_flag = 1'b1;
            n++;
            @(negedge CLK_1MHZ);
        end
        chk("timeout_len", n, 4095);
        chk("timeout_err", 32'(CFG_ERR), 32'd1);
        chk("timeout_busy", 32'(CFG_BUSY), 32'd0);
        chk("timeout_done", 32'(CFG_DONE), 32'd0);
        chk("timeout_go", 32'(SPI_GO), 32'd0);
        run_active = 1'b0;
        exp_q.delete();
        hang_en = 1'b0;
        repeat (20) begin
            if (SYNC) sync_flag = 1'b1;
            @(negedge CLK_1MHZ);
        end
        chk("timeout_no_sync", 32'(sync_flag), 32'd0);
        chk("timeout_err_hold", 32'(CFG_ERR), 32'd1);

        // Reset during GO_HI, then a fresh run from dev0/idx0
        load_expect();
        pulse_start();
        wait_busy("rst_busy");
        chk("rst_err_clr", 32'(CFG_ERR), 32'd0);
        g = 0;
        while (!SPI_GO && g < 50) begin
            @(negedge CLK_1MHZ);
            g++;
        end
        chk("rst_go_seen", 32'(g < 50), 32'd1);
        RST = 1'b0;
        #1;
        chk_all_zero("midrst");
        run_active = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge CLK_1MHZ);
        RST = 1'b1;
        load_expect();
        if (!AUTO) pulse_start();
        wait_busy("rerun_busy");
        finish_run();
        chk("rerun_first", first_word, 32'h0A00_0011);
        chk("rerun_total", go_total, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
